// File: rtl/dw_pkg.sv
// rtl/dw_pkg.sv - shared state encoding and width helpers for the depthwise conv scheduler
package dw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } dw_state_e;

  // Width of the ARM/DRAIN cycle counter; wide enough for any practical TIMEOUT.
  localparam int DW_CNT_W = 32;

  function automatic int dw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DW_DEF_ADDR_W = dw_width(112 * 112 * 16);
  localparam int DW_DEF_CH_W   = dw_width(16);

endpackage

// File: rtl/dw_fetch_counter.sv
// rtl/dw_fetch_counter.sv - c/x/y fetch coordinate walker, channel fastest, then x, then y
module dw_fetch_counter
  import dw_pkg::*;
#(
  parameter int CHANNELS  = 16,
  parameter int IN_WIDTH  = 112,
  parameter int IN_HEIGHT = 112
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_clear,
  input  logic                                            i_adv,
  output logic [dw_width(CHANNELS)-1:0]                   o_ch,
  output logic [dw_width(IN_WIDTH*IN_HEIGHT*CHANNELS)-1:0] o_addr,
  output logic                                            o_last
);

  localparam int CH_W   = dw_width(CHANNELS);
  localparam int X_W    = dw_width(IN_WIDTH);
  localparam int Y_W    = dw_width(IN_HEIGHT);
  localparam int ADDR_W = dw_width(IN_WIDTH * IN_HEIGHT * CHANNELS);

  localparam logic [CH_W-1:0] C_LAST = CH_W'(CHANNELS - 1);
  localparam logic [X_W-1:0]  X_LAST = X_W'(IN_WIDTH - 1);
  localparam logic [Y_W-1:0]  Y_LAST = Y_W'(IN_HEIGHT - 1);

  logic [CH_W-1:0]   r_c;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              w_c_wrap;
  logic              w_x_wrap;
  logic              w_y_wrap;

  assign w_c_wrap = (r_c == C_LAST);
  assign w_x_wrap = (r_x == X_LAST);
  assign w_y_wrap = (r_y == Y_LAST);
  assign o_last   = w_c_wrap && w_x_wrap && w_y_wrap;
  assign o_ch     = r_c;
  assign o_addr   = r_addr;

  // With channel fastest, (y*W+x)*C+c is simply the running fetch index,
  // so the address advances in lockstep instead of needing multipliers.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_c    <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (i_adv) begin
      r_addr <= o_last ? '0 : r_addr + ADDR_W'(1);
      if (w_c_wrap) begin
        r_c <= '0;
        if (w_x_wrap) begin
          r_x <= '0;
          r_y <= w_y_wrap ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end else begin
        r_c <= r_c + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/dw_conv_scheduler.sv
// rtl/dw_conv_scheduler.sv - streams one feature-map layer into the depthwise conv engine
module dw_conv_scheduler
  import dw_pkg::*;
#(
  parameter int N          = 16,
  parameter int CHANNELS   = 16,
  parameter int IN_WIDTH   = 112,
  parameter int IN_HEIGHT  = 112,
  parameter int ARM_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_start,
  input  logic                                            i_stall,
  output logic                                            o_fm_rd,
  output logic [dw_width(IN_WIDTH*IN_HEIGHT*CHANNELS)-1:0] o_fm_addr,
  input  logic [N-1:0]                                    i_fm_data,
  output logic                                            o_conv_en,
  output logic [N-1:0]                                    o_conv_data,
  output logic [dw_width(CHANNELS)-1:0]                   o_conv_ch,
  output logic                                            o_conv_valid,
  input  logic                                            i_conv_done,
  input  logic                                            i_conv_vout,
  output logic                                            o_busy,
  output logic                                            o_layer_done,
  output logic                                            o_error,
  output logic [31:0]                                     o_out_count
);

  localparam int CH_W   = dw_width(CHANNELS);
  localparam int ADDR_W = dw_width(IN_WIDTH * IN_HEIGHT * CHANNELS);

  localparam logic [DW_CNT_W-1:0] ARM_LAST = DW_CNT_W'(ARM_CYCLES - 1);
  localparam logic [DW_CNT_W-1:0] TO_LAST  = DW_CNT_W'(TIMEOUT - 1);

  dw_state_e           r_state;
  dw_state_e           w_next;
  logic [DW_CNT_W-1:0] r_cyc;
  logic                r_rd_d;
  logic [CH_W-1:0]     r_ch_d;
  logic                r_error;
  logic [31:0]         r_out_count;

  logic                w_fm_rd;
  logic                w_last;
  logic                w_clear;
  logic                w_timeout;
  logic                w_busy;
  logic                w_conv_en;
  logic                w_layer_done;
  logic [CH_W-1:0]     w_ch;
  logic [ADDR_W-1:0]   w_addr;

  dw_fetch_counter #(
    .CHANNELS (CHANNELS),
    .IN_WIDTH (IN_WIDTH),
    .IN_HEIGHT(IN_HEIGHT)
  ) u_fetch (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .i_adv  (w_fm_rd),
    .o_ch   (w_ch),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_fm_rd      = 1'b0;
    w_clear      = 1'b0;
    w_timeout    = 1'b0;
    w_busy       = 1'b1;
    w_conv_en    = 1'b0;
    w_layer_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_next  = ST_ARM;
          w_clear = 1'b1;
        end
      end
      ST_ARM: begin
        w_conv_en = 1'b1;
        if (r_cyc == ARM_LAST) begin
          w_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_conv_en = 1'b1;
        w_fm_rd   = !i_stall;
        if (w_fm_rd && w_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A done arriving on the timeout cycle is a clean finish.
        w_conv_en = 1'b1;
        if (i_conv_done) begin
          w_next = ST_FINISH;
        end else if (r_cyc == TO_LAST) begin
          w_next    = ST_FINISH;
          w_timeout = 1'b1;
        end
      end
      ST_FINISH: begin
        w_layer_done = 1'b1;
        w_next       = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc       <= '0;
      r_rd_d      <= 1'b0;
      r_ch_d      <= '0;
      r_error     <= 1'b0;
      r_out_count <= '0;
    end else begin
      // r_cyc counts cycles spent in the current state; ARM and DRAIN use it.
      r_cyc  <= (w_next != r_state) ? '0 : r_cyc + DW_CNT_W'(1);
      r_rd_d <= w_fm_rd;
      if (w_fm_rd) begin
        r_ch_d <= w_ch;
      end
      if (w_clear) begin
        r_error     <= 1'b0;
        r_out_count <= '0;
      end else begin
        if (w_timeout || (i_conv_done && (r_state == ST_ARM || r_state == ST_STREAM))) begin
          r_error <= 1'b1;
        end
        if (w_busy && i_conv_vout && (r_out_count != 32'hFFFF_FFFF)) begin
          r_out_count <= r_out_count + 32'd1;
        end
      end
    end
  end

  // Read data is passed straight through in the cycle after the fetch.
  assign o_conv_data  = r_rd_d ? i_fm_data : '0;
  assign o_conv_valid = r_rd_d;
  assign o_conv_ch    = r_ch_d;
  assign o_fm_rd      = w_fm_rd;
  assign o_fm_addr    = w_addr;
  assign o_conv_en    = w_conv_en;
  assign o_busy       = w_busy;
  assign o_layer_done = w_layer_done;
  assign o_error      = r_error;
  assign o_out_count  = r_out_count;

endmodule

// File: tb/tb_dw_conv_scheduler.sv
// tb/tb_dw_conv_scheduler.sv - scenario-table and randomized-stall bench for dw_conv_scheduler
module tb_dw_conv_scheduler;

  localparam int N   = 16;
  localparam int C   = 4;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int ARM = 4;
  localparam int TO  = 32;
  localparam int T   = C * W * H;
  localparam int AW  = $clog2(T);
  localparam int CW  = $clog2(C);

  typedef struct {
    int stall_at;
    int stall_len;
    int rnd_stall;
    int done_delay;
    int vout_n;
    int start_in_drain;
    int done_in_arm;
    int exp_err;
    int exp_lat;
    int exp_gap;
    int exp_count;
  } rec_t;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_stall;
  logic          o_fm_rd;
  logic [AW-1:0] o_fm_addr;
  logic [N-1:0]  i_fm_data;
  logic          o_conv_en;
  logic [N-1:0]  o_conv_data;
  logic [CW-1:0] o_conv_ch;
  logic          o_conv_valid;
  logic          i_conv_done;
  logic          i_conv_vout;
  logic          o_busy;
  logic          o_layer_done;
  logic          o_error;
  logic [31:0]   o_out_count;

  dw_conv_scheduler #(
    .N(N), .CHANNELS(C), .IN_WIDTH(W), .IN_HEIGHT(H), .ARM_CYCLES(ARM), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stall(i_stall),
    .o_fm_rd(o_fm_rd), .o_fm_addr(o_fm_addr), .i_fm_data(i_fm_data),
    .o_conv_en(o_conv_en), .o_conv_data(o_conv_data), .o_conv_ch(o_conv_ch),
    .o_conv_valid(o_conv_valid), .i_conv_done(i_conv_done), .i_conv_vout(i_conv_vout),
    .o_busy(o_busy), .o_layer_done(o_layer_done), .o_error(o_error), .o_out_count(o_out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  bit nx_rst = 1'b1, nx_start = 1'b0, nx_stall = 1'b0, nx_done = 1'b0, nx_vout = 1'b0;

  int cyc = 0, t_start = 0, tl = 0;
  bit active = 1'b0, have_last = 1'b0, prev_exp = 1'b0, drv_rd = 1'b0;
  int drv_addr = 0;
  int m_fetch = 0, m_deliv = 0;
  int d_fetch = 0, d_valid = 0, ld_cnt = 0, ld_cyc = 0, last_vcyc = -1, max_gap = 0;
  bit ld_en = 1'b0, cap_en_arm = 1'b0, cap_busy_arm = 1'b0, cap_en_drain = 1'b0;

  rec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Fetch index -> address, straight from the c/x/y ordering rule.
  function automatic int addr_of(input int idx);
    int c = idx % C;
    int x = (idx / C) % W;
    int y = idx / (C * W);
    return (y * W + x) * C + c;
  endfunction

  function automatic logic [N-1:0] data_of(input int a);
    return N'(a * 40503 + 4660);
  endfunction

  task automatic step();
    bit exp_rd;
    @(posedge clk);
    #1;
    rst         = nx_rst;
    i_start     = nx_start;
    i_stall     = nx_stall;
    i_conv_done = nx_done;
    i_conv_vout = nx_vout;
    i_fm_data   = drv_rd ? data_of(drv_addr) : N'($urandom);
    nx_start = 1'b0;
    nx_done  = 1'b0;
    nx_vout  = 1'b0;
    @(negedge clk);
    cyc++;
    exp_rd = active && (cyc >= t_start + ARM + 1) && (m_fetch < T) && !i_stall;
    chk("fm_rd", longint'(o_fm_rd), longint'(exp_rd));
    if (exp_rd) begin
      if (o_fm_rd) chk("fm_addr", longint'(o_fm_addr), longint'(addr_of(m_fetch)));
      m_fetch++;
      if (m_fetch == T) begin
        tl = cyc;
        have_last = 1'b1;
      end
    end
    chk("conv_valid", longint'(o_conv_valid), longint'(prev_exp));
    if (prev_exp && o_conv_valid) begin
      chk("conv_data", longint'(o_conv_data), longint'(data_of(addr_of(m_deliv))));
      chk("conv_ch", longint'(o_conv_ch), longint'(addr_of(m_deliv) % C));
    end
    if (prev_exp) m_deliv++;
    if (o_fm_rd) d_fetch++;
    if (o_conv_valid) begin
      d_valid++;
      if (last_vcyc >= 0 && cyc - last_vcyc - 1 > max_gap) max_gap = cyc - last_vcyc - 1;
      last_vcyc = cyc;
    end
    if (o_layer_done) begin
      ld_cnt++;
      ld_cyc = cyc;
      ld_en  = o_conv_en;
    end
    if (cyc == t_start + 1) begin
      cap_en_arm   = o_conv_en;
      cap_busy_arm = o_busy;
    end
    if (have_last && cyc == tl + 1) cap_en_drain = o_conv_en;
    prev_exp = exp_rd && !rst;
    drv_rd   = o_fm_rd;
    drv_addr = int'(o_fm_addr);
    if (rst) active = 1'b0;
  endtask

  task automatic begin_layer();
    m_fetch = 0; m_deliv = 0; have_last = 1'b0;
    d_fetch = 0; d_valid = 0; ld_cnt = 0; last_vcyc = -1; max_gap = 0;
    cap_en_arm = 1'b0; cap_busy_arm = 1'b0; cap_en_drain = 1'b0; ld_en = 1'b1;
    nx_stall = 1'b0;
    nx_start = 1'b1;
    t_start  = cyc + 1;
    active   = 1'b1;
    step();
  endtask

  task automatic run_layer(input rec_t r);
    int  stall_left = 0;
    bit  stall_done = 1'b0;
    int  vout_left  = r.vout_n;
    begin_layer();
    for (int k = 0; k < 1000 && ld_cnt == 0; k++) begin
      if (r.rnd_stall != 0) begin
        nx_stall = ($urandom_range(0, 3) == 0);
      end else begin
        if (r.stall_len > 0 && !stall_done && stall_left == 0 && m_fetch == r.stall_at)
          stall_left = r.stall_len;
        nx_stall = (stall_left > 0);
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stall_done = 1'b1;
        end
      end
      if (r.done_delay >= 0 && have_last && cyc + 1 == tl + r.done_delay) nx_done = 1'b1;
      if (r.done_in_arm != 0 && cyc + 1 == t_start + 2) nx_done = 1'b1;
      if (r.start_in_drain != 0 && have_last && cyc + 1 == tl + 3) nx_start = 1'b1;
      if (vout_left > 0 && m_fetch >= 2 && m_fetch < 60 && (cyc % 2) == 0) begin
        nx_vout = 1'b1;
        vout_left--;
      end
      step();
    end
    nx_stall = 1'b0;
    chk("layer_done_seen", ld_cnt, 1);
    chk("done_latency", ld_cyc - tl, r.exp_lat);
    chk("conv_en_finish", longint'(ld_en), 0);
    chk("conv_en_arm", longint'(cap_en_arm), 1);
    chk("busy_arm", longint'(cap_busy_arm), 1);
    chk("conv_en_drain", longint'(cap_en_drain), 1);
    nx_vout = 1'b1; step(); step();
    nx_vout = 1'b1; step(); step();
    chk("busy_idle", longint'(o_busy), 0);
    chk("conv_en_idle", longint'(o_conv_en), 0);
    chk("layer_done_once", ld_cnt, 1);
    chk("fetch_count", d_fetch, T);
    chk("valid_count", d_valid, T);
    if (r.exp_gap >= 0) chk("valid_gap", max_gap, r.exp_gap);
    chk("error", longint'(o_error), r.exp_err);
    chk("out_count", longint'(o_out_count), r.exp_count);
    active = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_conv_done = 1'b0; i_conv_vout = 1'b0;
    i_fm_data = '0;

    // stall_at len rnd done vout sdrain darm | err lat gap count
    tbl[0] = '{-1, 0, 0, -1,  0, 0, 0, 1, 33,  0,  0};
    tbl[1] = '{-1, 0, 0, 10,  0, 0, 0, 0, 11,  0,  0};
    tbl[2] = '{17, 3, 0, 10,  0, 0, 0, 0, 11,  3,  0};
    tbl[3] = '{-1, 0, 0, 10, 12, 0, 0, 0, 11,  0, 12};
    tbl[4] = '{-1, 0, 0, 10,  0, 1, 1, 1, 11,  0,  0};
    tbl[5] = '{-1, 0, 1, 10,  5, 0, 0, 0, 11, -1,  5};

    step(); step();
    nx_rst = 1'b0;
    step();
    chk("rst_fm_rd", longint'(o_fm_rd), 0);
    chk("rst_fm_addr", longint'(o_fm_addr), 0);
    chk("rst_conv_en", longint'(o_conv_en), 0);
    chk("rst_conv_valid", longint'(o_conv_valid), 0);
    chk("rst_conv_data", longint'(o_conv_data), 0);
    chk("rst_conv_ch", longint'(o_conv_ch), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_layer_done", longint'(o_layer_done), 0);
    chk("rst_error", longint'(o_error), 0);
    chk("rst_out_count", longint'(o_out_count), 0);

    for (int i = 0; i < 6; i++) run_layer(tbl[i]);

    // Reset while fetch 20 is being issued: everything clears, no layer_done.
    begin_layer();
    for (int k = 0; k < 200 && m_fetch < 20; k++) step();
    chk("midrst_reached_fetch20", m_fetch, 20);
    nx_rst = 1'b1;
    nx_vout = 1'b1;
    step();
    nx_rst = 1'b0;
    step();
    chk("midrst_fm_rd", longint'(o_fm_rd), 0);
    chk("midrst_fm_addr", longint'(o_fm_addr), 0);
    chk("midrst_conv_en", longint'(o_conv_en), 0);
    chk("midrst_conv_valid", longint'(o_conv_valid), 0);
    chk("midrst_conv_data", longint'(o_conv_data), 0);
    chk("midrst_conv_ch", longint'(o_conv_ch), 0);
    chk("midrst_busy", longint'(o_busy), 0);
    chk("midrst_error", longint'(o_error), 0);
    chk("midrst_out_count", longint'(o_out_count), 0);
    step(); step(); step();
    chk("midrst_no_layer_done", ld_cnt, 0);
    run_layer(tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
